// File: rtl/disp_msg_sequencer.sv
// disp_msg_sequencer: HI / scrolling HELLO / blinking HI show for a 4-digit mux (in: clk reset en btn_tick; out: in0..in3 busy step)
module disp_msg_sequencer #(
  parameter int TICK_DIV = 50000000,
  parameter int CW = $clog2(TICK_DIV),
  parameter int BLINK_N = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       btn_tick,
  output logic [7:0] in0,
  output logic [7:0] in1,
  output logic [7:0] in2,
  output logic [7:0] in3,
  output logic       busy,
  output logic [3:0] step
);
  typedef enum logic [1:0] {HELLO, SCROLL, BLINK} state_t;
  localparam int BW = $clog2(BLINK_N + 1);
  localparam logic [7:0] G_H = 8'b10001001;
  localparam logic [7:0] G_I = 8'b11111001;
  localparam logic [7:0] G_E = 8'b10000110;
  localparam logic [7:0] G_L = 8'b11000111;
  localparam logic [7:0] G_O = 8'b11000000;
  localparam logic [7:0] G_X = 8'b11111111;
  state_t state, nxt_state;
  logic [CW-1:0] timer, nxt_timer;
  logic [3:0] k, nxt_k;
  logic [BW-1:0] bc, nxt_bc;
  logic pulse;
  // scroll stream offset by 3 so that negative indices need no sign handling
  function automatic logic [7:0] glyph_at(input logic [3:0] i);
    return i == 4'd3 ? G_H : i == 4'd4 ? G_E : (i == 4'd5 || i == 4'd6) ? G_L : i == 4'd7 ? G_O : G_X;
  endfunction
  always_comb begin
    pulse = en && state != HELLO && timer == CW'(TICK_DIV - 1);
    nxt_state = state;
    nxt_timer = timer;
    nxt_k = k;
    nxt_bc = bc;
    if (en && btn_tick) begin
      nxt_state = state == HELLO ? SCROLL : HELLO;
      nxt_timer = '0;
      nxt_k = '0;
      nxt_bc = '0;
    end else if (en && state != HELLO) begin
      nxt_timer = pulse ? '0 : timer + CW'(1);
      if (pulse && state == SCROLL) begin
        nxt_state = k == 4'd8 ? BLINK : SCROLL;
        nxt_k = k == 4'd8 ? 4'd0 : k + 4'd1;
      end
      if (pulse && state == BLINK) begin
        nxt_state = bc == BW'(BLINK_N - 1) ? HELLO : BLINK;
        nxt_bc = bc == BW'(BLINK_N - 1) ? '0 : bc + BW'(1);
      end
    end
  end
  // outputs are decoded from the next-state values so they line up with the registered state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HELLO;
      timer <= '0;
      k <= '0;
      bc <= '0;
      in0 <= G_I;
      in1 <= G_H;
      in2 <= G_X;
      in3 <= G_X;
      busy <= 1'b0;
      step <= '0;
    end else begin
      state <= nxt_state;
      timer <= nxt_timer;
      k <= nxt_k;
      bc <= nxt_bc;
      in0 <= nxt_state == SCROLL ? glyph_at(nxt_k + 4'd3) : (nxt_state == BLINK && nxt_bc[0]) ? G_X : G_I;
      in1 <= nxt_state == SCROLL ? glyph_at(nxt_k + 4'd2) : (nxt_state == BLINK && nxt_bc[0]) ? G_X : G_H;
      in2 <= nxt_state == SCROLL ? glyph_at(nxt_k + 4'd1) : G_X;
      in3 <= nxt_state == SCROLL ? glyph_at(nxt_k) : G_X;
      busy <= nxt_state != HELLO;
      step <= nxt_state == SCROLL ? nxt_k : 4'd0;
    end
  end
endmodule

// File: tb/tb_disp_msg_sequencer.sv
// tb_disp_msg_sequencer: directed and random checks of disp_msg_sequencer against a cycle-count model
module tb_disp_msg_sequencer;
  localparam int TD = 4;
  localparam int BN = 4;
  localparam int SHOW = (9 + BN) * TD;
  logic clk = 0, reset = 1, en = 1, btn_tick = 0;
  logic [7:0] in0, in1, in2, in3;
  logic busy;
  logic [3:0] step;
  int checks = 0, failures = 0;
  bit running = 0;
  int n = 0;
  logic [7:0] s [0:8];
  disp_msg_sequencer #(.TICK_DIV(TD), .BLINK_N(BN)) dut (
    .clk(clk), .reset(reset), .en(en), .btn_tick(btn_tick),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .busy(busy), .step(step)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] sg(input int idx);
    return idx < 0 ? 8'hFF : s[idx];
  endfunction
  // expected {in3,in2,in1,in0,busy,step} from elapsed enabled cycles of the show
  function automatic logic [36:0] expv();
    int k, b;
    if (!running) return {32'hFFFF89F9, 1'b0, 4'd0};
    if (n < 9 * TD) begin
      k = n / TD;
      return {sg(k - 3), sg(k - 2), sg(k - 1), sg(k), 1'b1, 4'(k)};
    end
    b = (n - 9 * TD) / TD;
    return {(b % 2 == 0) ? 32'hFFFF89F9 : 32'hFFFFFFFF, 1'b1, 4'd0};
  endfunction
  function automatic logic [36:0] dutv();
    return {in3, in2, in1, in0, busy, step};
  endfunction
  task automatic cyc(input logic r, input logic e, input logic b);
    reset = r;
    en = e;
    btn_tick = b;
    @(posedge clk);
    if (r) begin
      running = 0;
      n = 0;
    end else if (e && b) begin
      running = !running;
      n = 0;
    end else if (e && running) begin
      n++;
      if (n == SHOW) begin
        running = 0;
        n = 0;
      end
    end
    #1;
    chk("model", 64'(dutv()), 64'(expv()));
  endtask
  task automatic run(input int c);
    for (int i = 0; i < c; i++) cyc(0, 1, 0);
  endtask
  initial begin
    logic [36:0] held;
    s[0] = 8'h89; s[1] = 8'h86; s[2] = 8'hC7; s[3] = 8'hC7; s[4] = 8'hC0;
    s[5] = 8'hFF; s[6] = 8'hFF; s[7] = 8'hFF; s[8] = 8'hFF;
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    chk("reset", 64'(dutv()), 64'({32'hFFFF89F9, 1'b0, 4'd0}));
    cyc(0, 1, 1);
    chk("busy_entry", 64'(busy), 64'd1);
    run(12);
    chk("step3", 64'(dutv()), 64'({32'h8986C7C7, 1'b1, 4'd3}));
    run(4);
    chk("step4", 64'(dutv()), 64'({32'h86C7C7C0, 1'b1, 4'd4}));
    run(16);
    chk("step8", 64'(dutv()), 64'({32'hFFFFFFFF, 1'b1, 4'd8}));
    run(3);
    chk("pre_blink", 64'(step), 64'd8);
    run(1);
    chk("blink0", 64'(dutv()), 64'({32'hFFFF89F9, 1'b1, 4'd0}));
    run(4);
    chk("blink1", 64'(dutv()), 64'({32'hFFFFFFFF, 1'b1, 4'd0}));
    run(11);
    chk("pre_return", 64'(busy), 64'd1);
    run(1);
    chk("return", 64'(dutv()), 64'({32'hFFFF89F9, 1'b0, 4'd0}));
    cyc(0, 1, 1);
    run(9);
    held = dutv();
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, i == 4);
      chk("freeze", 64'(dutv()), 64'(held));
    end
    run(2);
    chk("resume2", 64'(step), 64'd2);
    run(1);
    chk("resume3", 64'(step), 64'd3);
    cyc(1, 1, 0);
    chk("reset_mid", 64'(dutv()), 64'({32'hFFFF89F9, 1'b0, 4'd0}));
    cyc(0, 1, 1);
    run(40);
    cyc(0, 1, 1);
    chk("abort_blink", 64'(dutv()), 64'({32'hFFFF89F9, 1'b0, 4'd0}));
    cyc(0, 1, 1);
    run(3);
    cyc(0, 1, 1);
    chk("abort_pulse", 64'(dutv()), 64'({32'hFFFF89F9, 1'b0, 4'd0}));
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 69) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/disp_msg_sequencer.md
Name: disp_msg_sequencer

Overview:
- Display scheduler that owns the four 8-bit digit inputs (in0..in3) of the 4-digit seven-segment multiplexer.
- Sequences a fixed message show: idle "HI", then a right-to-left scroll of "HELLO", then a blinking "HI".
- Triggered by the one-cycle debounced button tick from the button debouncer.
- Sits between the debouncer and the display mux and replaces hard-wired digit constants in the top level.

Parameters:
- TICK_DIV, 50000000, clk cycles per animation step (0.5 s at 100 MHz); must be ≥ 2.
- CW, $clog2(TICK_DIV), width of the step timer.
- BLINK_N, 6, number of on/off toggles in BLINK; must be even and ≥ 2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  1 = sequencer runs; 0 = freeze state, timer and outputs
- btn_tick  input  1  one-cycle pulse from button debouncer
- in0  output  8  rightmost digit pattern to display mux
- in1  output  8  digit 1 pattern
- in2  output  8  digit 2 pattern
- in3  output  8  leftmost digit pattern
- busy  output  1  1 while in SCROLL or BLINK
- step  output  4  current scroll step index (0 outside SCROLL)

Behaviour:
- Glyphs are active-low {dp,g,f,e,d,c,b,a}:
  - H=8'b10001001, I=8'b11111001, E=8'b10000110
  - L=8'b11000111, O=8'b11000000, OFF=8'b11111111
- Reset (clk edge with reset=1):
  - state=HELLO, timer=0, step=0, blink count=0, busy=0
  - in0=I, in1=H, in2=OFF, in3=OFF
  - reset has priority over every other input, including mid-SCROL/BLINK.
- All outputs are registered and reflect the state/step of the previous edge (1-cycle latency from the transition).
- Timer:
  - Counts 0..TICK_DIV-1 only in SCROLL or BLINK with en=1.
  - step_pulse is asserted when timer==TICK_DIV-1, and the timer wraps to 0 on that cycle.
  - Timer is cleared to 0 on every state entry.
- en=0: state, timer, step, blink count and outputs all hold; btn_tick is ignored (not queued).
- States:
  - HELLO:
    - Outputs I,H,OFF,OFF on in0..in3.
    - btn_tick & en: go to SCROLL with step=0 and timer=0.
  - SCROLL:
    - Stream S[0..8] = H,E,L,L,O,OFF,OFF,OFF,OFF; S[negative index]=OFF.
    - At step k: in0=S[k], in1=S[k-1], in2=S[k-2], in3=S[k-3].
    - step_pulse with k<8: k increments.
    - step_pulse with k==8: go to BLINK with blink count=0.
  - BLINK:
    - Even blink count: shows HELLO pattern (I,H,OFF,OFF). Odd blink count: all four digits OFF.
    - step_pulse: blink count increments; when it reaches BLINK_N, go to HELLO.
- btn_tick & en while in SCROLL or BLINK aborts to HELLO on the next edge, clearing timer, step and blink count.
- btn_tick coincident with step_pulse: abort wins.
- step output reads 0 in HELLO and BLINK.
- busy=1 exactly when registered state is SCROLL or BLINK.
- A full show takes 9 steps of SCROLL plus BLINK_N steps of BLINK, i.e. 9·TICK_DIV + BLINK_N·TICK_DIV cycles from the entry edge to the HELLO return.

Test Plan:
- Bench configuration: TICK_DIV=4, BLINK_N=4.
- Reset: assert reset 2 cycles, release.
  - Required: in0=8'hF9, in1=8'h89, in2=in3=8'hFF, busy=0, step=0.
  - Then apply reset mid-SCROLL at step 3: same values on the next edge.
- Full scroll: pulse btn_tick once.
  - Required: busy=1 one cycle later; step advances every 4 cycles.
  - At step 3: in3..in0 = 89,86,C7,C7.
  - At step 4: 86,C7,C7,C0.
  - At step 8: all FF.
  - Enters BLINK 36 cycles after entry.
- Blink and return: after scroll, outputs alternate (F9,89,FF,FF) / all FF every 4 cycles for 4 toggles; HELLO and busy=0 at 36+16=52 cycles after entry.
- Freeze: drop en for 10 cycles at step 2 and pulse btn_tick while en=0.
  - Required: outputs and step unchanged, tick ignored.
  - Scroll resumes at the same timer value after en returns to 1.
- Abort: btn_tick during BLINK, and btn_tick in the same cycle as a step_pulse in SCROLL.
  - Required: HELLO pattern, busy=0, step=0 on the next edge.
